hex_word_printer: RTL and testbench



---
 rtl/hex_word_printer.sv | 118 +++++++++++
 tb/tb_hex_word_printer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_word_printer.sv
// Serializes a 4*word_nibbles-bit word as lowercase ASCII hex, MS nibble first,
// with an optional "0x" prefix and optional CR LF. The downstream byte channel is fully registered.
module hex_word_printer #(
  parameter int word_nibbles = 8,
  parameter bit emit_prefix  = 1'b1,
  parameter bit emit_newline = 1'b1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [4*word_nibbles-1:0] in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [7:0]                out_byte,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy
);
  localparam int W  = 4 * word_nibbles;
  localparam int CW = (word_nibbles > 1) ? $clog2(word_nibbles) : 1;
  localparam logic [CW-1:0] LAST = CW'(word_nibbles - 1);

  typedef enum logic [2:0] {IDLE, PFX0, PFX1, DIGIT, CR, LF} state_t;

  state_t        r_state;
  logic [W-1:0]  r_word;
  logic [CW-1:0] r_cnt;

  logic [CW-1:0] w_idx;
  logic [3:0]    w_nib;
  logic [3:0]    w_top;
  logic          w_xfer;
  logic          w_accept;

  function automatic logic [7:0] hex_char(input logic [3:0] v);
    return (v < 4'd10) ? {4'h3, v} : (8'h57 + {4'h0, v});
  endfunction

  assign w_xfer   = out_valid && out_ready;
  assign w_accept = in_valid && in_ready;
  assign w_top    = in_data[W-1 -: 4];

  // Index of the digit to present next: 0 when leaving the prefix, cnt+1 inside the digits.
  always_comb begin
    w_idx = (r_state == DIGIT) ? (r_cnt + CW'(1)) : '0;
    w_nib = '0;
    for (int k = 0; k < word_nibbles; k++)
      if (w_idx == CW'(k)) w_nib = r_word[4*(word_nibbles-1-k) +: 4];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_word    <= '0;
      r_cnt     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_byte  <= 8'h00;
      busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_word    <= in_data;
          r_cnt     <= '0;
          in_ready  <= 1'b0;
          out_valid <= 1'b1;
          busy      <= 1'b1;
          if (emit_prefix) begin
            r_state  <= PFX0;
            out_byte <= 8'h30;
          end else begin
            r_state  <= DIGIT;
            out_byte <= hex_char(w_top);
          end
        end
        PFX0: if (w_xfer) begin
          r_state  <= PFX1;
          out_byte <= 8'h78;
        end
        PFX1: if (w_xfer) begin
          r_state  <= DIGIT;
          out_byte <= hex_char(w_nib);
        end
        DIGIT: if (w_xfer) begin
          if (r_cnt == LAST) begin
            if (emit_newline) begin
              r_state  <= CR;
              out_byte <= 8'h0D;
            end else begin
              r_state   <= IDLE;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              in_ready  <= 1'b1;
            end
          end else begin
            r_cnt    <= r_cnt + CW'(1);
            out_byte <= hex_char(w_nib);
          end
        end
        CR: if (w_xfer) begin
          r_state  <= LF;
          out_byte <= 8'h0A;
        end
        LF: if (w_xfer) begin
          r_state   <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
        default: begin
          r_state   <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_hex_word_printer.sv
// Directed bench for hex_word_printer: default build plus two reduced builds.
// Inputs change and outputs are sampled on the falling edge.
module tb_hex_word_printer;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // default instance
  logic [31:0] d0_data;
  logic        d0_valid, d0_iready, d0_ovalid, d0_oready, d0_busy;
  logic [7:0]  d0_byte;
  // word_nibbles=2, no prefix, no newline
  logic [7:0]  d1_data;
  logic        d1_valid, d1_iready, d1_ovalid, d1_oready, d1_busy;
  logic [7:0]  d1_byte;
  // word_nibbles=1, no prefix, newline
  logic [3:0]  d2_data;
  logic        d2_valid, d2_iready, d2_ovalid, d2_oready, d2_busy;
  logic [7:0]  d2_byte;

  hex_word_printer u0 (
    .clock(clock), .reset(reset), .in_data(d0_data), .in_valid(d0_valid),
    .in_ready(d0_iready), .out_byte(d0_byte), .out_valid(d0_ovalid),
    .out_ready(d0_oready), .busy(d0_busy));

  hex_word_printer #(.word_nibbles(2), .emit_prefix(1'b0), .emit_newline(1'b0)) u1 (
    .clock(clock), .reset(reset), .in_data(d1_data), .in_valid(d1_valid),
    .in_ready(d1_iready), .out_byte(d1_byte), .out_valid(d1_ovalid),
    .out_ready(d1_oready), .busy(d1_busy));

  hex_word_printer #(.word_nibbles(1), .emit_prefix(1'b0), .emit_newline(1'b1)) u2 (
    .clock(clock), .reset(reset), .in_data(d2_data), .in_valid(d2_valid),
    .in_ready(d2_iready), .out_byte(d2_byte), .out_valid(d2_ovalid),
    .out_ready(d2_oready), .busy(d2_busy));

  task automatic test_reset;
    reset = 1'b1;
    @(negedge clock); @(negedge clock);
    reset = 1'b0;
    checks++;
    if ({d0_iready, d0_ovalid, d0_busy, d0_byte} !== {3'b100, 8'h00}) begin
      errors++;
      $display("FAIL reset_u0 got rdy=%b vld=%b busy=%b byte=%h want 1 0 0 00",
               d0_iready, d0_ovalid, d0_busy, d0_byte);
    end
    checks++;
    if ({d1_iready, d1_ovalid, d1_busy, d1_byte, d2_iready, d2_ovalid, d2_busy, d2_byte}
        !== {3'b100, 8'h00, 3'b100, 8'h00}) begin
      errors++;
      $display("FAIL reset_small got u1 %b%b%b %h u2 %b%b%b %h want 100 00",
               d1_iready, d1_ovalid, d1_busy, d1_byte, d2_iready, d2_ovalid, d2_busy, d2_byte);
    end
  endtask

  // Accept one word on u0 with out_ready high and check 12 back-to-back bytes.
  task automatic test_stream(input logic [31:0] data, input logic [95:0] exp, input string name);
    d0_oready = 1'b1;
    d0_data   = data;
    d0_valid  = 1'b1;
    @(negedge clock);
    d0_valid  = 1'b0;
    d0_data   = 32'h0;
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (!(d0_ovalid === 1'b1 && d0_byte === exp[95-8*i -: 8] && d0_busy === 1'b1)) begin
        errors++;
        $display("FAIL %s byte%0d got vld=%b busy=%b %h want 1 1 %h",
                 name, i, d0_ovalid, d0_busy, d0_byte, exp[95-8*i -: 8]);
      end
      @(negedge clock);
    end
    checks++;
    if ({d0_iready, d0_ovalid, d0_busy} !== 3'b100) begin
      errors++;
      $display("FAIL %s_end got rdy=%b vld=%b busy=%b want 1 0 0",
               name, d0_iready, d0_ovalid, d0_busy);
    end
  endtask

  task automatic test_backpressure;
    logic [95:0] exp;
    exp = 96'h30_78_30_30_30_30_30_30_30_66_0D_0A;
    d0_oready = 1'b0;
    d0_data   = 32'h0000000F;
    d0_valid  = 1'b1;
    @(negedge clock);
    d0_valid  = 1'b0;
    for (int i = 0; i < 12; i++) begin
      for (int s = 0; s < 6; s++) begin
        checks++;
        if (!(d0_ovalid === 1'b1 && d0_byte === exp[95-8*i -: 8])) begin
          errors++;
          $display("FAIL stall byte%0d cyc%0d got vld=%b %h want 1 %h",
                   i, s, d0_ovalid, d0_byte, exp[95-8*i -: 8]);
        end
        if (s == 5) d0_oready = 1'b1;
        @(negedge clock);
        d0_oready = 1'b0;
      end
    end
    checks++;
    if ({d0_iready, d0_ovalid, d0_busy} !== 3'b100) begin
      errors++;
      $display("FAIL stall_end got rdy=%b vld=%b busy=%b want 1 0 0",
               d0_iready, d0_ovalid, d0_busy);
    end
  endtask

  task automatic test_back_to_back;
    logic [95:0] exp1, exp2;
    exp1 = 96'h30_78_31_32_33_34_35_36_37_38_0D_0A;
    exp2 = 96'h30_78_66_66_66_66_66_66_66_66_0D_0A;
    d0_oready = 1'b1;
    d0_data   = 32'h12345678;
    d0_valid  = 1'b1;
    @(negedge clock);
    d0_data   = 32'hFFFFFFFF;
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (!(d0_ovalid === 1'b1 && d0_byte === exp1[95-8*i -: 8] && d0_iready === 1'b0)) begin
        errors++;
        $display("FAIL b2b_w1 byte%0d got vld=%b rdy=%b %h want 1 0 %h",
                 i, d0_ovalid, d0_iready, d0_byte, exp1[95-8*i -: 8]);
      end
      @(negedge clock);
    end
    checks++;
    if ({d0_iready, d0_ovalid} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_gap got rdy=%b vld=%b want 1 0", d0_iready, d0_ovalid);
    end
    @(negedge clock);
    d0_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (!(d0_ovalid === 1'b1 && d0_byte === exp2[95-8*i -: 8])) begin
        errors++;
        $display("FAIL b2b_w2 byte%0d got vld=%b %h want 1 %h",
                 i, d0_ovalid, d0_byte, exp2[95-8*i -: 8]);
      end
      @(negedge clock);
    end
    checks++;
    if ({d0_iready, d0_busy} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_end got rdy=%b busy=%b want 1 0", d0_iready, d0_busy);
    end
  endtask

  task automatic test_reset_mid;
    logic [23:0] exp;
    exp = 24'h30_78_63;
    d0_oready = 1'b1;
    d0_data   = 32'hCAFEF00D;
    d0_valid  = 1'b1;
    @(negedge clock);
    d0_valid  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (!(d0_ovalid === 1'b1 && d0_byte === exp[23-8*i -: 8])) begin
        errors++;
        $display("FAIL rstmid byte%0d got vld=%b %h want 1 %h",
                 i, d0_ovalid, d0_byte, exp[23-8*i -: 8]);
      end
      @(negedge clock);
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checks++;
    if ({d0_iready, d0_ovalid, d0_busy, d0_byte} !== {3'b100, 8'h00}) begin
      errors++;
      $display("FAIL rstmid_after got rdy=%b vld=%b busy=%b %h want 1 0 0 00",
               d0_iready, d0_ovalid, d0_busy, d0_byte);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checks++;
      if (d0_ovalid !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_quiet cyc%0d got vld=%b want 0", i, d0_ovalid);
      end
    end
    test_stream(32'h0123ABCD, 96'h30_78_30_31_32_33_61_62_63_64_0D_0A, "rstmid_new");
  endtask

  task automatic test_small;
    d1_oready = 1'b1;
    d1_data   = 8'hA5;
    d1_valid  = 1'b1;
    d2_oready = 1'b1;
    d2_data   = 4'h9;
    d2_valid  = 1'b1;
    @(negedge clock);
    d1_valid = 1'b0;
    d2_valid = 1'b0;
    checks++;
    if ({d1_ovalid, d1_byte, d2_ovalid, d2_byte} !== {1'b1, 8'h61, 1'b1, 8'h39}) begin
      errors++;
      $display("FAIL small_b0 got u1 %b %h u2 %b %h want 1 61 1 39",
               d1_ovalid, d1_byte, d2_ovalid, d2_byte);
    end
    @(negedge clock);
    checks++;
    if ({d1_ovalid, d1_byte, d2_ovalid, d2_byte} !== {1'b1, 8'h35, 1'b1, 8'h0D}) begin
      errors++;
      $display("FAIL small_b1 got u1 %b %h u2 %b %h want 1 35 1 0d",
               d1_ovalid, d1_byte, d2_ovalid, d2_byte);
    end
    @(negedge clock);
    checks++;
    if ({d1_ovalid, d1_iready, d1_busy, d2_ovalid, d2_byte} !== {3'b010, 1'b1, 8'h0A}) begin
      errors++;
      $display("FAIL small_b2 got u1 vld=%b rdy=%b busy=%b u2 %b %h want 0 1 0 / 1 0a",
               d1_ovalid, d1_iready, d1_busy, d2_ovalid, d2_byte);
    end
    @(negedge clock);
    checks++;
    if ({d2_ovalid, d2_iready, d2_busy} !== 3'b010) begin
      errors++;
      $display("FAIL small_u2_end got vld=%b rdy=%b busy=%b want 0 1 0",
               d2_ovalid, d2_iready, d2_busy);
    end
  endtask

  initial begin
    reset = 1'b1;
    d0_data = '0; d0_valid = 1'b0; d0_oready = 1'b1;
    d1_data = '0; d1_valid = 1'b0; d1_oready = 1'b1;
    d2_data = '0; d2_valid = 1'b0; d2_oready = 1'b1;
    @(negedge clock);
    test_reset();
    test_stream(32'hDEADBEEF, 96'h30_78_64_65_61_64_62_65_65_66_0D_0A, "deadbeef");
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_small();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
